// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared state encoding, slot timing and requester indices for the data-island scheduler.
package hdmi_pkg;
    typedef enum logic [2:0] {IDLE, PRE, GL, PKT, GT} state_t;
    localparam int GUARD_LEN = 2;
    localparam int PKT_LEN = 32;
    localparam int REQ_ACR = 0;
    localparam int REQ_AUD = 1;
    localparam int REQ_AVI = 2;
    localparam int REQ_AIF = 3;
endpackage

// File: rtl/hdmi_rr_arbiter.sv
// hdmi_rr_arbiter: index 0 wins outright, others round-robin within 1..NREQ-1 starting at ptr.
module hdmi_rr_arbiter
    import hdmi_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   ptr_next
);
    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        ptr_next = ptr;
        found = 1'b0;
        idx = '0;
        if (req[REQ_ACR]) begin
            grant[REQ_ACR] = 1'b1;
            found = 1'b1;
        end
        for (int i = 0; i < NREQ - 1; i++) begin
            idx = PW'((int'(ptr) - 1 + i) % (NREQ - 1) + 1);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found = 1'b1;
                ptr_next = (idx == PW'(NREQ - 1)) ? PW'(1) : idx + PW'(1);
            end
        end
    end
endmodule

// File: rtl/hdmi_island_scheduler.sv
// hdmi_island_scheduler: sequences preamble/guard/packet slots in hblank and grants one source per slot.
// Optional per-frame packet counter on o_frame_pkts when HDMI_ISLAND_STATS_EN is defined.
module hdmi_island_scheduler
    import hdmi_pkg::*;
#(
    parameter int   NREQ = 4,
    parameter int   MAX_PKTS = 2,
    parameter logic HSYNC_POL = 1'b0,
    parameter int   PREAMBLE_LEN = 8
) (
    input  logic            i_pixclk,
    input  logic            i_reset,
    input  logic            i_enable,
    input  logic            i_hSync,
    input  logic            i_vSync,
    input  logic            i_blank,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_grant,
    output logic            o_pkt_start,
    output logic [4:0]      o_pkt_phase,
    output logic            o_preamble,
    output logic            o_guard,
    output logic            o_island,
    output logic            o_overrun
`ifdef HDMI_ISLAND_STATS_EN
    ,
    output logic [15:0]     o_frame_pkts
`endif
);
    localparam int PW = $clog2(NREQ);

    state_t          state, state_next;
    logic [7:0]      cnt;
    logic [4:0]      pkt_cnt;
    logic            hsync_q;
    logic [PW-1:0]   ptr, ptr_next;
    logic [NREQ-1:0] arb_grant;
    logic            abort, trigger, last, more, enter_pkt;

    hdmi_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req(i_req),
        .ptr(ptr),
        .grant(arb_grant),
        .ptr_next(ptr_next)
    );

    assign abort = state != IDLE && !i_blank;
    assign trigger = i_hSync == HSYNC_POL && hsync_q != HSYNC_POL && i_blank && i_enable && |i_req;
    assign last = state == PRE ? cnt == 8'(PREAMBLE_LEN - 1) :
                  state == PKT ? cnt == 8'(PKT_LEN - 1) : cnt == 8'(GUARD_LEN - 1);
    assign more = pkt_cnt < 5'(MAX_PKTS) && |i_req;
    // Arbitration fires on the cycle before each slot, including back-to-back slots.
    assign enter_pkt = state_next == PKT && (state != PKT || last);

    always_ff @(posedge i_pixclk) begin
        state <= i_reset ? IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = trigger ? PRE : IDLE;
            PRE:     if (last) state_next = GL;
            GL:      if (last) state_next = PKT;
            PKT:     if (last) state_next = more ? PKT : GT;
            GT:      if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_comb begin
        o_preamble = state == PRE;
        o_guard = state == GL || state == GT;
        o_island = state == PKT;
        o_pkt_start = o_island && cnt == '0;
        o_pkt_phase = o_island ? cnt[4:0] : '0;
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            hsync_q <= HSYNC_POL;
            cnt <= '0;
            pkt_cnt <= '0;
            o_grant <= '0;
            ptr <= PW'(1);
            o_overrun <= 1'b0;
        end else begin
            hsync_q <= i_hSync;
            cnt <= (state_next != state || enter_pkt) ? '0 : cnt + 8'd1;
            pkt_cnt <= state == IDLE ? '0 :
                       (o_pkt_start && pkt_cnt < 5'(MAX_PKTS)) ? pkt_cnt + 5'd1 : pkt_cnt;
            o_grant <= enter_pkt ? arb_grant : state_next == PKT ? o_grant : '0;
            if (enter_pkt) ptr <= ptr_next;
            if (abort) o_overrun <= 1'b1;
        end
    end

`ifdef HDMI_ISLAND_STATS_EN
    logic        vsync_q;
    logic [15:0] frame_cnt;

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            vsync_q <= 1'b0;
            frame_cnt <= '0;
            o_frame_pkts <= '0;
        end else begin
            vsync_q <= i_vSync;
            if (i_vSync && !vsync_q) begin
                o_frame_pkts <= frame_cnt;
                frame_cnt <= {15'd0, o_pkt_start};
            end else if (o_pkt_start && frame_cnt != 16'hFFFF) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_vsync;
    assign unused_vsync = i_vSync;
`endif
endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// tb_hdmi_island_scheduler: directed line-by-line stimulus with a grant scoreboard checked per packet slot.
module tb_hdmi_island_scheduler;
    logic       clk = 1'b0;
    logic       rst, en, hs, vs, blank;
    logic [3:0] req;
    logic [3:0] grant;
    logic       pkt_start, preamble, guard, island, overrun;
    logic [4:0] pkt_phase;
    int         total = 0, bad = 0;
    int         npre = 0, ngrd = 0, nisl = 0, nact = 0;
    logic [3:0] exp_q[$];
`ifdef HDMI_ISLAND_STATS_EN
    logic [15:0] frame_pkts;
`endif

    always #5 clk = ~clk;

    hdmi_island_scheduler dut (
        .i_pixclk(clk),
        .i_reset(rst),
        .i_enable(en),
        .i_hSync(hs),
        .i_vSync(vs),
        .i_blank(blank),
        .i_req(req),
        .o_grant(grant),
        .o_pkt_start(pkt_start),
        .o_pkt_phase(pkt_phase),
        .o_preamble(preamble),
        .o_guard(guard),
        .o_island(island),
        .o_overrun(overrun)
`ifdef HDMI_ISLAND_STATS_EN
        ,
        .o_frame_pkts(frame_pkts)
`endif
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Pops one expected grant per slot start and checks the grant holds through the slot.
    task automatic monitor();
        logic [3:0] cur = '0;
        forever begin
            @(negedge clk);
            if (preamble) npre++;
            if (guard) ngrd++;
            if (island) nisl++;
            if (preamble || guard || island) nact++;
            if (pkt_start) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_slot: got grant 0x%0h want no slot", grant);
                end else begin
                    cur = exp_q.pop_front();
                    check("slot_grant", {12'd0, grant}, {12'd0, cur});
                end
            end else if (island) begin
                check("grant_hold", {12'd0, grant}, {12'd0, cur});
            end
        end
    endtask

    // One 160-cycle line: hsync active (low) on cycles 4..11, blank for cycles < blank_len.
    task automatic line(input logic [3:0] r, input int rdly, input logic [3:0] oneshot,
                        input int blank_len, input int rst_at);
        for (int c = 0; c < 160; c++) begin
            @(posedge clk);
            #1;
            hs = !(c >= 4 && c < 12);
            blank = c < blank_len;
            if (c == 0) req = rdly == 0 ? r : 4'b0;
            else if (c == 4 + rdly) req = r;
            if (pkt_start) req = req & ~(grant & oneshot);
            rst = c == rst_at;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        hs = 1'b1;
        blank = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int a, p, g, i;
        rst = 1'b1;
        en = 1'b1;
        hs = 1'b1;
        vs = 1'b0;
        blank = 1'b0;
        req = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {grant, pkt_start, pkt_phase, preamble, guard, island, overrun}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        exp_q.push_back(4'b0010);
        a = nact; p = npre; g = ngrd; i = nisl;
        line(4'b0010, 0, 4'b0010, 140, -1);
        check("single_preamble", 16'(npre - p), 16'd8);
        check("single_guard", 16'(ngrd - g), 16'd4);
        check("single_island", 16'(nisl - i), 16'd32);
        check("single_total", 16'(nact - a), 16'd44);
        check("single_drained", 16'(exp_q.size()), 16'd0);

        do_reset();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        i = nisl;
        line(4'b1111, 0, 4'b0001, 140, -1);
        check("two_slot_island", 16'(nisl - i), 16'd64);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        line(4'b1110, 0, 4'b0000, 140, -1);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        line(4'b1110, 0, 4'b0000, 140, -1);

        en = 1'b0;
        a = nact;
        line(4'b1110, 0, 4'b0000, 140, -1);
        check("disabled_no_island", 16'(nact - a), 16'd0);
        en = 1'b1;

        a = nact;
        line(4'b0010, 1, 4'b0010, 140, -1);
        check("late_req_no_island", 16'(nact - a), 16'd0);
        exp_q.push_back(4'b0010);
        a = nact;
        line(4'b0010, 0, 4'b0010, 140, -1);
        check("next_line_island", 16'(nact - a), 16'd44);

        check("overrun_clear", {15'd0, overrun}, 16'd0);
        exp_q.push_back(4'b0010);
        a = nact; i = nisl;
        line(4'b0010, 0, 4'b0010, 25, -1);
        check("abort_island", 16'(nisl - i), 16'd11);
        check("abort_total", 16'(nact - a), 16'd21);
        check("abort_overrun", {15'd0, overrun}, 16'd1);
        exp_q.push_back(4'b0100);
        a = nact;
        line(4'b0100, 0, 4'b0100, 140, -1);
        check("post_abort_total", 16'(nact - a), 16'd44);
        check("overrun_sticky", {15'd0, overrun}, 16'd1);
        do_reset();
        @(negedge clk);
        check("overrun_reset", {15'd0, overrun}, 16'd0);

        exp_q.push_back(4'b0010);
        line(4'b0010, 0, 4'b0010, 140, -1);
        exp_q.push_back(4'b0100);
        a = nact; i = nisl;
        line(4'b1110, 0, 4'b0000, 140, 20);
        check("midreset_island", 16'(nisl - i), 16'd6);
        check("midreset_total", 16'(nact - a), 16'd16);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        i = nisl;
        line(4'b1110, 0, 4'b0000, 140, -1);
        check("post_reset_island", 16'(nisl - i), 16'd64);

`ifdef HDMI_ISLAND_STATS_EN
        do_reset();
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        repeat (3) line(4'b1110, 0, 4'b0000, 140, -1);
        @(posedge clk);
        #1;
        vs = 1'b1;
        @(posedge clk);
        #1;
        vs = 1'b0;
        @(negedge clk);
        check("frame_pkts", frame_pkts, 16'd6);
`endif

        repeat (4) @(posedge clk);
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hdmi_island_scheduler.md
Name: hdmi_island_scheduler

Overview:
- Sequences HDMI data-island periods during horizontal blanking and arbitrates packet slots between packet sources: audio clock regen, audio samples, AVI infoframe and audio infoframe.
- Sits between the sync/blank timing generator and the packet encoder/TERC4 stage.
- Emits preamble, guard-band and packet-slot timing plus a one-hot grant per 32-cycle packet slot.

Parameters:
- NREQ, 4, number of requesters. Index 0 is strict-priority (ACR); indices 1..NREQ-1 are round-robin.
- MAX_PKTS, 2, maximum packets per island (1..18).
- HSYNC_POL, 0, active level of i_hSync.
- PREAMBLE_LEN, 8, preamble cycles before the leading guard band.

Ports:
- i_pixclk  in  1  pixel clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  allow new islands
- i_hSync  in  1  horizontal sync
- i_vSync  in  1  vertical sync
- i_blank  in  1  high during blanking
- i_req  in  NREQ  packet-ready level per source
- o_grant  out  NREQ  one-hot grant, valid for the whole packet slot
- o_pkt_start  out  1  1-cycle pulse on the first cycle of each packet slot
- o_pkt_phase  out  5  cycle index 0..31 within the current packet
- o_preamble  out  1  data-island preamble active
- o_guard  out  1  data-island guard band active
- o_island  out  1  packet-slot cycles only; drives the encoder's data enable
- o_overrun  out  1  sticky; island was cut short by the end of blanking

Behaviour:
- Reset: state IDLE; all outputs 0; round-robin pointer selects index 1.
- Island trigger: a cycle where i_hSync first equals HSYNC_POL (edge against a registered copy), with i_blank=1, i_enable=1 and |i_req=1.
- If there is no request at the trigger, no island starts that line.
- State machine:
  - IDLE -> PRE on trigger.
  - PRE (PREAMBLE_LEN cycles, o_preamble=1) -> GL.
  - GL (2 cycles, o_guard=1) -> PKT.
  - PKT (32 cycles per packet, o_island=1, o_pkt_phase 0..31):
    - At phase 31, go to another PKT if the packet count is below MAX_PKTS and |i_req=1.
    - Otherwise go to GT.
  - GT (2 cycles, o_guard=1) -> IDLE.
- Arbitration:
  - Evaluated combinationally on the cycle entering each PKT slot.
  - Registered grant appears together with o_pkt_start at phase 0.
  - i_req[0] always wins.
  - Otherwise the lowest index at or after the RR pointer wins, wrapping within 1..NREQ-1.
  - After an RR grant, the pointer moves to granted index+1 (wraps to 1). A grant to index 0 leaves the pointer unchanged.
- Handshake: o_pkt_start & o_grant[k] acknowledges requester k. The requester deasserts i_req[k] within 32 cycles unless it has another packet ready.
- o_grant holds for all 32 cycles of the slot, then clears in GT/IDLE.
- Packet count resets in IDLE. It increments at each o_pkt_start and saturates at MAX_PKTS.
- Abort: if i_blank=0 in any non-IDLE state:
  - go to IDLE next cycle and clear all outputs;
  - set o_overrun (cleared only by reset);
  - the RR pointer keeps the value it was updated to at that slot's grant.
- i_enable falling mid-island: the current island completes normally, and no further triggers are accepted.
- Triggers arriving while not IDLE are ignored.
- i_vSync passes through only to the optional statistics; it has no scheduling effect.
- Reset asserted mid-island: all outputs are 0 on the next edge.

Optional Feature:
- Macro HDMI_ISLAND_STATS_EN.
- When defined, adds output o_frame_pkts[15:0]:
  - counts o_pkt_start pulses;
  - latched and counter cleared on each i_vSync rising edge;
  - saturates at 16'hFFFF;
  - reset value 0.
- When undefined, the port and counter are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package hdmi_pkg:
  - state enum {IDLE, PRE, GL, PKT, GT};
  - constants GUARD_LEN=2, PKT_LEN=32;
  - requester indices REQ_ACR=0, REQ_AUD=1, REQ_AVI=2, REQ_AIF=3.
- Sub-module hdmi_rr_arbiter (NREQ): priority-plus-round-robin grant and pointer update.

Test Plan:
- i_req=4'b0010, hsync edge in blank -> o_preamble 8 cycles, o_guard 2, one 32-cycle slot with o_grant=0010, o_guard 2, IDLE; total 44 cycles.
- i_req=4'b1111 held, MAX_PKTS=2 -> slot1 grant 0001, slot2 grant 0010; next line slot2 grant 0100, then 1000, then 0010.
- i_req=0 at the hsync edge, then asserted 1 cycle later -> no island that line; island starts on the next line's edge.
- i_blank falls at phase 10 of slot 1 -> outputs 0 the next cycle, o_overrun=1 and stays 1 until i_reset.
- i_reset pulsed during PKT phase 5 -> all outputs 0 the following cycle; next island grants index 1 first among RR sources.
- With HDMI_ISLAND_STATS_EN, 3 lines × 2 packets, then an i_vSync rise -> o_frame_pkts=6.
